// File: rtl/pulse_peak_pkg.sv
// Shared types and helpers for the pulse peak capture block: detector states,
// default widths and the peak-to-report slicing function.
package pulse_peak_pkg;

    localparam int ADC_W_DEF = 14;
    localparam int OUT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_PULSE = 2'd1,
        ST_HOLDOFF  = 2'd2
    } state_e;

    // Keeps the top out_w bits of an adc_w-wide peak; plain truncation, no rounding.
    function automatic logic [31:0] peak_slice(input logic [31:0] peak,
                                               input int         adc_w,
                                               input int         out_w);
        logic [31:0] mask;
        mask = (32'h1 << out_w) - 32'h1;
        return (peak >> (adc_w - out_w)) & mask;
    endfunction

endpackage

// File: rtl/pulse_peak_capture_fifo.sv
// peak_fifo: synchronous FIFO with first-word-through head. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module peak_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_en, rd_en;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Full + pop: the write lands in the slot being vacated, which is safe
    // because the head is read combinationally this same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pulse_peak_capture.sv
// Pulse detector, peak tracker and toggle-handshake presenter feeding the HPS PIO.
// Define PULSE_HOLDOFF_EN to add a dead-time of HOLDOFF valid samples after each pulse.
module pulse_peak_capture
    import pulse_peak_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int HOLDOFF    = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADC_W-1:0]              adc_data,
    input  logic                          adc_valid,
    input  logic [ADC_W-1:0]              threshold,
    input  logic                          ack_toggle,
    output logic [OUT_W:0]                sample_word,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (HOLDOFF < 1 || OUT_W > ADC_W) begin : g_bad_params
        $error("HOLDOFF must be >= 1 and OUT_W <= ADC_W");
    end

    state_e            state_q, state_d;
    logic [ADC_W-1:0]  peak_q, peak_d;
    logic              push_q, push_d;
    logic [OUT_W-1:0]  push_data_q, push_data_d;
    logic [OUT_W:0]    word_q, word_d;
    logic              presented_q, presented_d;
    logic              overflow_q, overflow_d;
    logic              above, pop;
    logic [OUT_W-1:0]  fifo_head;
    logic              fifo_full, fifo_empty;

`ifdef PULSE_HOLDOFF_EN
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    logic [HCW-1:0]    hcnt_q, hcnt_d;
`endif

    assign above = adc_data > threshold;

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
`ifdef PULSE_HOLDOFF_EN
        hcnt_d      = hcnt_q;
`endif
        if (adc_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (above) begin
                        state_d = ST_IN_PULSE;
                        peak_d  = adc_data;
                    end
                end
                ST_IN_PULSE: begin
                    if (above) begin
                        if (adc_data > peak_q) peak_d = adc_data;
                    end else begin
                        // Registered push: the FIFO write lands the cycle after the end sample.
                        push_d      = 1'b1;
                        push_data_d = OUT_W'(peak_slice(32'(peak_q), ADC_W, OUT_W));
`ifdef PULSE_HOLDOFF_EN
                        state_d     = ST_HOLDOFF;
                        hcnt_d      = '0;
`else
                        state_d     = ST_IDLE;
`endif
                    end
                end
`ifdef PULSE_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (hcnt_q == HCW'(HOLDOFF - 1)) begin
                        state_d = ST_IDLE;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d  = hcnt_q + HCW'(1);
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    peak_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // The word is outstanding until the HPS mirrors its toggle back on ack_toggle.
    always_comb begin
        pop         = !presented_q && !fifo_empty;
        word_d      = word_q;
        presented_d = presented_q;
        if (pop) begin
            word_d      = {~word_q[OUT_W], fifo_head};
            presented_d = 1'b1;
        end else if (presented_q && (ack_toggle == word_q[OUT_W])) begin
            presented_d = 1'b0;
        end
        overflow_d = overflow_q | (push_q & fifo_full & ~pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            peak_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            word_q      <= '0;
            presented_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef PULSE_HOLDOFF_EN
            hcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            word_q      <= word_d;
            presented_q <= presented_d;
            overflow_q  <= overflow_d;
`ifdef PULSE_HOLDOFF_EN
            hcnt_q      <= hcnt_d;
`endif
        end
    end

    assign sample_word = word_q;
    assign overflow    = overflow_q;

endmodule
